// File: rtl/seq_alu_if.sv
// Handshake and result bus between the microsequencer (master) and seq_alu (slave).
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             ready;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             err;
  logic             done;

  modport master (
    output start, alu_op, op_a, op_b,
    input  ready, result, zero, neg, carry, err, done
  );

  modport slave (
    input  start, alu_op, op_a, op_b,
    output ready, result, zero, neg, carry, err, done
  );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU with start/ready/done handshake: single-cycle logic/arith/shift ops
// plus an iterative shift-add multiplier taking WIDTH cycles.
module seq_alu #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input logic      clk,
  input logic      rst_n,
  seq_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam logic [WIDTH:0]   EXT_ONE  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   EXT_FOUR = EXT_ONE << 2;
  localparam logic [WIDTH-1:0] ONE      = EXT_ONE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] FOUR     = EXT_FOUR[WIDTH-1:0];
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIN} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_ready;
  logic             w_done;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_last_iter;

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] w_acc_next;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_neg;
  logic             r_carry;
  logic             r_err;

  logic [SHW-1:0]   w_sh;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_err;

  assign w_sh        = bus.op_b[SHW-1:0];
  assign w_accept    = bus.start & w_ready;
  assign w_is_mul    = MUL_EN && (bus.alu_op == 4'd14);
  assign w_last_iter = (r_count == CNT_LAST);
  assign w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // Single-cycle result; codes not handled here (15, and 14 without a multiplier) are illegal.
  always_comb begin
    w_sum   = '0;
    w_res   = '0;
    w_carry = 1'b0;
    w_err   = 1'b0;
    case (bus.alu_op)
      4'd0: w_res = bus.op_a;
      4'd1: w_res = bus.op_b;
      4'd2: begin
        w_sum   = {1'b0, bus.op_a} + EXT_ONE;
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      4'd3: begin
        w_res   = bus.op_a - ONE;
        w_carry = (bus.op_a >= ONE);
      end
      4'd4: begin
        w_sum   = {1'b0, bus.op_a} + EXT_FOUR;
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      4'd5: begin
        w_res   = bus.op_a - FOUR;
        w_carry = (bus.op_a >= FOUR);
      end
      4'd6: begin
        w_sum   = {1'b0, bus.op_a} + {1'b0, bus.op_b};
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      4'd7: begin
        w_res   = bus.op_a - bus.op_b;
        w_carry = (bus.op_a >= bus.op_b);
      end
      4'd8:  w_res = bus.op_a & bus.op_b;
      4'd9:  w_res = bus.op_a | bus.op_b;
      4'd10: w_res = bus.op_a ^ bus.op_b;
      4'd11: w_res = bus.op_a << w_sh;
      4'd12: w_res = bus.op_a >> w_sh;
      4'd13: w_res = $signed(bus.op_a) >>> w_sh;
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_MUL:   w_state_next = w_last_iter ? S_FIN : S_MUL;
      default: begin
        if (w_accept) begin
          w_state_next = w_is_mul ? S_MUL : S_FIN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    w_ready = (r_state != S_MUL);
    w_done  = (r_state == S_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_carry  <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      if (w_is_mul) begin
        r_mcand  <= bus.op_a;
        r_mplier <= bus.op_b;
        r_acc    <= '0;
        r_count  <= '0;
      end else begin
        r_result <= w_res;
        r_zero   <= (w_res == '0);
        r_neg    <= w_res[WIDTH-1];
        r_carry  <= w_carry;
        r_err    <= w_err;
      end
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + CNT_ONE;
      if (w_last_iter) begin
        r_result <= w_acc_next;
        r_zero   <= (w_acc_next == '0);
        r_neg    <= w_acc_next[WIDTH-1];
        r_carry  <= 1'b0;
        r_err    <= 1'b0;
      end
    end
  end

  assign bus.ready  = w_ready;
  assign bus.done   = w_done;
  assign bus.result = r_result;
  assign bus.zero   = r_zero;
  assign bus.neg    = r_neg;
  assign bus.carry  = r_carry;
  assign bus.err    = r_err;
endmodule

// File: tb/tb_seq_alu.sv
// Directed and randomized checks of seq_alu against an arithmetic reference model.
module tb_seq_alu;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  seq_alu_if #(.WIDTH(32)) bus ();
  seq_alu_if #(.WIDTH(32)) bus0 ();

  seq_alu #(.WIDTH(32), .MUL_EN(1'b1)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  seq_alu #(.WIDTH(32), .MUL_EN(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {err, carry, result} from the op definitions using wide unsigned arithmetic.
  function automatic logic [33:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input bit mul_en);
    longint unsigned ua, ub, full;
    int sh;
    logic [31:0] r;
    logic c, e;
    ua = a; ub = b; sh = int'(b % 32); c = 1'b0; e = 1'b0; r = '0; full = 0;
    case (op)
      4'd0:  r = a;
      4'd1:  r = b;
      4'd2:  begin full = ua + 1; r = full[31:0]; c = full[32]; end
      4'd3:  begin r = a - 32'd1; c = (ua >= 1); end
      4'd4:  begin full = ua + 4; r = full[31:0]; c = full[32]; end
      4'd5:  begin r = a - 32'd4; c = (ua >= 4); end
      4'd6:  begin full = ua + ub; r = full[31:0]; c = full[32]; end
      4'd7:  begin r = a - b; c = (ua >= ub); end
      4'd8:  r = a & b;
      4'd9:  r = a | b;
      4'd10: r = a ^ b;
      4'd11: r = a << sh;
      4'd12: r = a >> sh;
      4'd13: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'd14: begin
        if (mul_en) begin full = ua * ub; r = full[31:0]; end
        else e = 1'b1;
      end
      default: e = 1'b1;
    endcase
    return {e, c, r};
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [33:0] m;
    int n;
    m = model(op, a, b, 1'b1);
    chk({tag, "/ready_pre"}, bus.ready, 1);
    bus.start = 1'b1; bus.alu_op = op; bus.op_a = a; bus.op_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    if (op == 4'd14) begin
      while (!bus.done && n < 100) begin
        chk({tag, "/ready_busy"}, bus.ready, 0);
        @(posedge clk); #1;
        n++;
      end
    end
    chk({tag, "/latency"}, n, (op == 4'd14) ? 32 : 0);
    chk({tag, "/done"}, bus.done, 1);
    chk({tag, "/result"}, bus.result, m[31:0]);
    chk({tag, "/zero"}, bus.zero, (m[31:0] == 32'h0));
    chk({tag, "/neg"}, bus.neg, m[31]);
    chk({tag, "/carry"}, bus.carry, m[32]);
    chk({tag, "/err"}, bus.err, m[33]);
    $display("txn %s op=%0d a=%08h b=%08h result=%08h z=%0b n=%0b c=%0b e=%0b", tag, op, a, b,
             bus.result, bus.zero, bus.neg, bus.carry, bus.err);
    @(posedge clk); #1;
    chk({tag, "/done_low"}, bus.done, 0);
    chk({tag, "/ready_post"}, bus.ready, 1);
  endtask

  initial begin
    int n;
    int done_seen;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    n_checks = 0; n_fail = 0;
    bus.start = 1'b0;  bus.alu_op = '0;  bus.op_a = '0;  bus.op_b = '0;
    bus0.start = 1'b0; bus0.alu_op = '0; bus0.op_a = '0; bus0.op_b = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/result", bus.result, 0);
    chk("reset/done", bus.done, 0);
    chk("reset/flags", {bus.zero, bus.neg, bus.carry, bus.err}, 4'b0000);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset/ready", bus.ready, 1);
    chk("reset/done_after", bus.done, 0);

    run_op(4'd6,  32'hFFFF_FFFF, 32'h1, "add_wrap");
    run_op(4'd7,  32'd5, 32'd7, "sub_5_7");
    run_op(4'd5,  32'd4, 32'd0, "dec4_4");
    run_op(4'd13, 32'h8000_0000, 32'h24, "sra");
    run_op(4'd12, 32'h8000_0000, 32'h24, "srl");
    run_op(4'd11, 32'h1, 32'd31, "sll");
    run_op(4'd3,  32'h0, 32'h0, "dec1_0");
    run_op(4'd4,  32'hFFFF_FFFE, 32'h0, "inc4_wrap");

    // Multiply with an ignored start pulse and an operand change while busy.
    bus.start = 1'b1; bus.alu_op = 4'd14; bus.op_a = 32'h0001_2345; bus.op_b = 32'h100;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 100) begin
      chk("mul_iso/ready_busy", bus.ready, 0);
      bus.start = (n == 5);
      if (n == 5) bus.alu_op = 4'd6;
      if (n == 10) bus.op_a = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    chk("mul_iso/latency", n, 32);
    chk("mul_iso/result", bus.result, 32'h0123_4500);
    chk("mul_iso/flags", {bus.zero, bus.neg, bus.carry, bus.err}, 4'b0000);
    $display("txn mul_iso result=%08h cycles=%0d", bus.result, n);
    @(posedge clk); #1;
    chk("mul_iso/done_low", bus.done, 0);
    chk("mul_iso/hold", bus.result, 32'h0123_4500);

    // Asynchronous reset during the tenth multiply iteration.
    bus.start = 1'b1; bus.alu_op = 4'd14; bus.op_a = 32'h0001_2345; bus.op_b = 32'h100;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    #2; rst_n = 1'b0; #1;
    chk("mul_rst/result", bus.result, 0);
    chk("mul_rst/done", bus.done, 0);
    chk("mul_rst/flags", {bus.zero, bus.neg, bus.carry, bus.err}, 4'b0000);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mul_rst/ready", bus.ready, 1);
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    chk("mul_rst/no_done", done_seen, 0);
    $display("txn mul_rst result=%08h done_pulses=%0d", bus.result, done_seen);

    // Illegal op followed back-to-back by ADD with start held high.
    bus.start = 1'b1; bus.alu_op = 4'd15; bus.op_a = 32'd123; bus.op_b = 32'd456;
    @(posedge clk); #1;
    chk("ill15/done", bus.done, 1);
    chk("ill15/result", bus.result, 0);
    chk("ill15/flags", {bus.zero, bus.neg, bus.carry, bus.err}, 4'b1001);
    $display("txn ill15 result=%08h err=%0b", bus.result, bus.err);
    bus.alu_op = 4'd6; bus.op_a = 32'd2; bus.op_b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_add/done", bus.done, 1);
    chk("b2b_add/result", bus.result, 32'd5);
    chk("b2b_add/flags", {bus.zero, bus.neg, bus.carry, bus.err}, 4'b0000);
    $display("txn b2b_add result=%08h err=%0b", bus.result, bus.err);
    @(posedge clk); #1;
    chk("b2b_add/done_low", bus.done, 0);

    // Multiplier disabled: op 14 is illegal and single-cycle.
    bus0.start = 1'b1; bus0.alu_op = 4'd6; bus0.op_a = 32'h7FFF_FFFF; bus0.op_b = 32'h1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    chk("nomul_add/result", bus0.result, 32'h8000_0000);
    chk("nomul_add/flags", {bus0.zero, bus0.neg, bus0.carry, bus0.err}, 4'b0100);
    @(posedge clk); #1;
    bus0.start = 1'b1; bus0.alu_op = 4'd14; bus0.op_a = 32'd3; bus0.op_b = 32'd5;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    chk("nomul14/done", bus0.done, 1);
    chk("nomul14/ready", bus0.ready, 1);
    chk("nomul14/result", bus0.result, 0);
    chk("nomul14/flags", {bus0.zero, bus0.neg, bus0.carry, bus0.err}, 4'b1001);
    $display("txn nomul14 result=%08h err=%0b", bus0.result, bus0.err);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFFF;
      if ($urandom_range(0, 5) == 0) rb = ra;
      run_op(rop, ra, rb, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the processor's combinational ALU.
- Keeps the existing 4-bit op encodings 0–9 and adds XOR, barrel shifts and an iterative shift-add multiply.
- Uses a start/ready/done handshake and a registered result with flags (zero, negative, carry, error).
- Sits between the datapath bus and the microsequencer; the microcode waits on done before latching the result onto the bus.

Parameters:
- WIDTH, 32, operand/result width; power of two, 8 or more.
- MUL_EN, 1, 1 = MUL op implemented; 0 = MUL treated as illegal.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when ready=1
- ready  out  1  block can accept start this cycle
- alu_op  in  4  operation, sampled at accept
- op_a  in  WIDTH  operand A, sampled at accept
- op_b  in  WIDTH  operand B, sampled at accept
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- neg  out  1  result[WIDTH-1]
- carry  out  1  carry/no-borrow flag
- err  out  1  illegal operation flag
- done  out  1  one-cycle pulse: result and flags updated

Behaviour:
- **Reset** (rst_n=0, asynchronous, any state, including mid-multiply):
  - state=IDLE, result=0, zero=0, neg=0, carry=0, err=0, done=0, iteration counter=0.
  - ready=1 once rst_n deasserts.
- **States:** IDLE, MUL, FIN.
  - ready=1 in IDLE and FIN; ready=0 in MUL.
- **Accept:** start=1 and ready=1 at rising edge k. Operands and op are registered at k.
- **start when ready=0:** ignored; no queueing.
- **Single-cycle ops** (codes 0–13, 15): result and flags written at edge k; done=1 for the cycle after k; state=FIN.
- **Op codes:**
  - 0 COPY_A: A
  - 1 COPY_B: B
  - 2 INC_A_1: A+1
  - 3 DEC_A_1: A-1
  - 4 INC_A_4: A+4
  - 5 DEC_A_4: A-4
  - 6 ADD: A+B
  - 7 SUB: A-B
  - 8 AND: A&B
  - 9 OR: A|B
  - 10 XOR: A^B
  - 11 SLL: A<<sh
  - 12 SRL: A>>sh, logical
  - 13 SRA: A>>sh, arithmetic
  - 14 MUL: low WIDTH bits of A*B, unsigned
  - 15: illegal
- **Shift amount:** sh = op_b[$clog2(WIDTH)-1:0]; upper bits of op_b ignored.
- **Arithmetic width:** all arithmetic is modulo 2^WIDTH.
- **carry:**
  - ADD/INC: carry = carry-out of bit WIDTH-1.
  - SUB/DEC: carry = 1 when no borrow (minuend >= subtrahend, unsigned).
  - All other ops: carry = 0.
- **zero and neg:** always computed from the new result value written in the same edge, never from the previous result.
- **MUL (MUL_EN=1):**
  - At edge k: load mcand=A, mplier=B, acc=0, count=0; state=MUL.
  - Each edge in MUL: if mplier[0], acc += mcand; mcand <<= 1; mplier >>= 1; count++.
  - The WIDTH-th iteration falls at edge k+WIDTH. At that edge: result = final acc, flags updated (carry=0), state=FIN.
  - done=1 for the cycle after edge k+WIDTH.
- **Illegal op** (code 15, or code 14 with MUL_EN=0): single-cycle; result=0, zero=1, neg=0, carry=0, err=1.
- **err:** cleared on the next accepted legal op.
- **FIN state:** behaves like IDLE, but done=1 for its first cycle only.
  - A start during the done cycle is accepted (back-to-back, no bubble).
  - Without start, next state is IDLE.
- **Hold:** result and flags hold their values until the next completion.
- **Operand isolation:** op_a/op_b/alu_op changes after accept have no effect on the op in flight.

Test Plan (WIDTH=32, MUL_EN=1 unless stated):
1. ADD, op_a=0xFFFFFFFF, op_b=1 → result=0, zero=1, carry=1, neg=0; done high exactly the cycle after accept; ready never drops.
2. SUB 5−7 → result=0xFFFFFFFE, neg=1, carry=0, zero=0. Then DEC_A_4 on A=4 → result=0, zero=1, carry=1.
3. SRA A=0x80000000, op_b=0x24 (sh=4) → 0xF8000000. SRL with the same inputs → 0x08000000. SLL A=1, op_b=31 → 0x80000000.
4. MUL 0x00012345 × 0x00000100 → 0x01234500.
   - ready=0 for 32 cycles; done exactly 32 edges after accept.
   - A start pulse mid-operation is ignored.
   - Changing op_a mid-operation does not alter the result.
5. rst_n pulsed low during iteration 10 of MUL → all outputs 0 immediately (asynchronous); ready=1 after release; no done pulse ever appears.
6. Op 15 → err=1, result=0, zero=1. A start held high through the done cycle with ADD 2+3 is accepted back-to-back → result=5, err=0. Repeat op 14 with MUL_EN=0 → err=1.
